effect_mode_controller: RTL and testbench

Sequences the vocal-effect datapath and the on-screen effect labels from six raw push-buttons. It debounces the buttons and runs a mutually-exclusive effect-selection FSM with a click-free mute interval on every change. It also owns the saturating pitch-shift setting and drives the HIGH/LOW/ECHO/PITCH/UP/DOWN highlight flags consumed by `color_mapper`, updating them only at frame start.

---
 rtl/effect_pkg.sv | 33 +++
 rtl/button_debounce.sv | 54 +++++
 rtl/effect_mode_controller.sv | 165 ++++++++++++++++
 tb/tb_effect_mode_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/effect_pkg.sv
// Shared effect encodings, FSM states and the effect-to-one-hot decode
// used by both the mode controller and the audio datapath.
package effect_pkg;

    typedef enum logic [2:0] {
        EFF_NONE  = 3'd0,
        EFF_HIGH  = 3'd1,
        EFF_LOW   = 3'd2,
        EFF_ECHO  = 3'd3,
        EFF_PITCH = 3'd4
    } effect_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUTE   = 2'd1,
        S_ACTIVE = 2'd2
    } fsm_state_t;

    // One-hot decode ordered {PITCH, ECHO, LOW, HIGH}; EFF_NONE decodes to zero.
    function automatic logic [3:0] effect_onehot(input effect_t e);
        logic [3:0] oh;
        oh = '0;
        case (e)
            EFF_HIGH:  oh = 4'b0001;
            EFF_LOW:   oh = 4'b0010;
            EFF_ECHO:  oh = 4'b0100;
            EFF_PITCH: oh = 4'b1000;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stable-level debouncer
// and a registered rising-edge press pulse. Releases produce no pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q;

    // Two-stage synchronizer for the asynchronous button level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], btn_i};
    end

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync_q[1];
            else                   cnt_d    = cnt_q + CW'(1);
        end
    end

    // Debounced level, its delayed copy and the registered rising-edge press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
            press_q  <= stable_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/effect_mode_controller.sv
// Effect-selection controller: debounced buttons, mutually-exclusive effect
// FSM with a click-free mute on every change, saturating pitch shift and
// frame-synchronous display highlight flags.
module effect_mode_controller
    import effect_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MUTE_CYCLES     = 2400,
    parameter int unsigned PITCH_MAX       = 7,
    parameter int unsigned FLASH_FRAMES    = 15
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       btn_high,
    input  logic       btn_low,
    input  logic       btn_echo,
    input  logic       btn_pitch,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       frame_start,
    output logic [2:0] effect_sel,
    output logic       audio_mute,
    output logic [3:0] pitch_shift,
    output logic       HIGH,
    output logic       LOW,
    output logic       ECHO,
    output logic       PITCH,
    output logic       UP,
    output logic       DOWN
);

    localparam int unsigned MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [MW-1:0] MUTE_LOAD = MW'(MUTE_CYCLES - 1);
    localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic signed [3:0] P_HI = 4'(PITCH_MAX);
    localparam logic signed [3:0] P_LO = -P_HI;

    logic p_high, p_low, p_echo, p_pitch, p_up, p_down;

    fsm_state_t        state_q, state_d;
    effect_t           cur_q, cur_d;
    effect_t           nxt_q, nxt_d;
    logic [MW-1:0]     mute_cnt_q, mute_cnt_d;
    logic signed [3:0] pitch_q, pitch_d;
    logic [FW-1:0]     up_cnt_q, up_cnt_d;
    logic [FW-1:0]     dn_cnt_q, dn_cnt_d;
    logic [3:0]        flags_q;
    logic              up_flag_q, dn_flag_q;

    effect_t eff_req;
    logic    eff_press;
    logic    step_ok;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_high  (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_high),  .press_o(p_high));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_low   (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_low),   .press_o(p_low));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_echo  (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_echo),  .press_o(p_echo));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pitch (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_pitch), .press_o(p_pitch));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_up),    .press_o(p_up));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk_i(Clk), .rst_ni(reset_n), .btn_i(btn_down),  .press_o(p_down));

    // Fixed-priority pick among simultaneous effect presses: high > low > echo > pitch.
    always_comb begin
        eff_req   = EFF_NONE;
        eff_press = p_high | p_low | p_echo | p_pitch;
        if      (p_high)  eff_req = EFF_HIGH;
        else if (p_low)   eff_req = EFF_LOW;
        else if (p_echo)  eff_req = EFF_ECHO;
        else if (p_pitch) eff_req = EFF_PITCH;
    end

    // Effect FSM next state: any press starts a mute, the target is applied on its last cycle.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        mute_cnt_d = mute_cnt_q;
        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (eff_press) begin
                    nxt_d      = (eff_req == cur_q) ? EFF_NONE : eff_req;
                    mute_cnt_d = MUTE_LOAD;
                    state_d    = S_MUTE;
                end
            end
            S_MUTE: begin
                if (mute_cnt_q == '0) begin
                    cur_d   = nxt_q;
                    state_d = (nxt_q == EFF_NONE) ? S_IDLE : S_ACTIVE;
                end else begin
                    mute_cnt_d = mute_cnt_q - MW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pitch stepping with saturation and UP/DOWN flash counters.
    always_comb begin
        pitch_d  = pitch_q;
        up_cnt_d = up_cnt_q;
        dn_cnt_d = dn_cnt_q;
        step_ok  = (cur_q == EFF_PITCH) && (state_q != S_MUTE) && (p_up ^ p_down);
        if (frame_start) begin
            if (up_cnt_q != '0) up_cnt_d = up_cnt_q - FW'(1);
            if (dn_cnt_q != '0) dn_cnt_d = dn_cnt_q - FW'(1);
        end
        if (step_ok && p_up) begin
            if (pitch_q < P_HI) pitch_d = pitch_q + 4'sd1;
            up_cnt_d = FLASH_LOAD;
            dn_cnt_d = '0;
        end else if (step_ok && p_down) begin
            if (pitch_q > P_LO) pitch_d = pitch_q - 4'sd1;
            dn_cnt_d = FLASH_LOAD;
            up_cnt_d = '0;
        end
        // Zeroed on the same edge cur is replaced, so no stale shift leaks into another effect.
        if (cur_d != EFF_PITCH) pitch_d = '0;
    end

    // Controller state registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cur_q      <= EFF_NONE;
            nxt_q      <= EFF_NONE;
            mute_cnt_q <= '0;
            pitch_q    <= '0;
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            mute_cnt_q <= mute_cnt_d;
            pitch_q    <= pitch_d;
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
        end
    end

    // Display shadow flags, refreshed only at frame start from the pre-edge state.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q   <= '0;
            up_flag_q <= 1'b0;
            dn_flag_q <= 1'b0;
        end else if (frame_start) begin
            flags_q   <= effect_onehot(cur_q);
            up_flag_q <= (up_cnt_q != '0);
            dn_flag_q <= (dn_cnt_q != '0);
        end
    end

    assign effect_sel  = cur_q;
    assign audio_mute  = (state_q == S_MUTE);
    assign pitch_shift = pitch_q;
    assign HIGH        = flags_q[0];
    assign LOW         = flags_q[1];
    assign ECHO        = flags_q[2];
    assign PITCH       = flags_q[3];
    assign UP          = up_flag_q;
    assign DOWN        = dn_flag_q;

endmodule

// File: tb/tb_effect_mode_controller.sv
// Directed bench for effect_mode_controller with short debounce/mute settings.
module tb_effect_mode_controller;

    logic       Clk;
    logic       reset_n;
    logic [5:0] btn;          // {down, up, pitch, echo, low, high}
    logic       frame_start;
    logic [2:0] effect_sel;
    logic       audio_mute;
    logic [3:0] pitch_shift;
    logic       HIGH, LOW, ECHO, PITCH, UP, DOWN;

    int checks = 0;
    int errors = 0;

    effect_mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .MUTE_CYCLES(8),
        .PITCH_MAX(7),
        .FLASH_FRAMES(15)
    ) dut (
        .Clk(Clk), .reset_n(reset_n),
        .btn_high(btn[0]), .btn_low(btn[1]), .btn_echo(btn[2]),
        .btn_pitch(btn[3]), .btn_up(btn[4]), .btn_down(btn[5]),
        .frame_start(frame_start),
        .effect_sel(effect_sel), .audio_mute(audio_mute), .pitch_shift(pitch_shift),
        .HIGH(HIGH), .LOW(LOW), .ECHO(ECHO), .PITCH(PITCH), .UP(UP), .DOWN(DOWN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0] mask;
        logic [2:0] sel;
        logic [3:0] flags;   // {PITCH, ECHO, LOW, HIGH}
    } vec_t;

    vec_t tbl [5];
    logic [3:0] prev_flags;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_mute_rise(input string name);
        int n;
        n = 0;
        while (!audio_mute && n < 40) begin
            step();
            n++;
        end
        if (!audio_mute) chk({name, "_mute_rise_timeout"}, 0, 1);
    endtask

    task automatic mute_len(output int n);
        n = 0;
        while (audio_mute && n < 50) begin
            n++;
            step();
        end
    endtask

    // Press a set of buttons, verify the mute window length and the applied effect.
    task automatic do_eff(input string name, input logic [5:0] mask, input int exp_sel);
        int n;
        btn = mask;
        wait_mute_rise(name);
        mute_len(n);
        chk({name, "_mute_len"}, n, 8);
        chk({name, "_sel"}, int'(effect_sel), exp_sel);
        btn = '0;
        repeat (12) step();
    endtask

    task automatic press_step(input logic [5:0] mask);
        btn = mask;
        repeat (12) step();
        btn = '0;
        repeat (12) step();
    endtask

    initial begin
        int n, rises, mutes;
        logic prev;

        tbl[0] = '{mask: 6'b000100, sel: 3'd3, flags: 4'b0100}; // echo on
        tbl[1] = '{mask: 6'b000100, sel: 3'd0, flags: 4'b0000}; // echo toggles off
        tbl[2] = '{mask: 6'b001010, sel: 3'd2, flags: 4'b0010}; // low beats pitch
        tbl[3] = '{mask: 6'b000010, sel: 3'd0, flags: 4'b0000}; // low toggles off
        tbl[4] = '{mask: 6'b001000, sel: 3'd4, flags: 4'b1000}; // pitch on

        reset_n     = 1'b0;
        btn         = '0;
        frame_start = 1'b0;

        // Reset held with buttons chattering: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            btn = 6'($urandom);
            step();
            chk("rst_outs", int'({effect_sel, audio_mute, pitch_shift, HIGH, LOW, ECHO, PITCH, UP, DOWN}), 0);
        end
        btn = '0;
        step();
        reset_n = 1'b1;
        repeat (20) step();
        chk("post_rst_sel", int'(effect_sel), 0);
        chk("post_rst_mute", int'(audio_mute), 0);

        // Table: effect presses, flags only move at the next frame start.
        prev_flags = '0;
        for (int i = 0; i < 5; i++) begin
            do_eff($sformatf("vec%0d", i), tbl[i].mask, int'(tbl[i].sel));
            chk($sformatf("vec%0d_flags_hold", i), int'({PITCH, ECHO, LOW, HIGH}), int'(prev_flags));
            frame();
            chk($sformatf("vec%0d_flags", i), int'({PITCH, ECHO, LOW, HIGH}), int'(tbl[i].flags));
            prev_flags = tbl[i].flags;
        end

        // Pitch: nine ups saturate at +7.
        chk("pitch_start", int'($signed(pitch_shift)), 0);
        for (int i = 0; i < 9; i++) begin
            press_step(6'b010000);
            chk($sformatf("up%0d", i), int'($signed(pitch_shift)), (i + 1 > 7) ? 7 : i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            frame();
            chk($sformatf("up_flag_f%0d", i), int'(UP), 1);
        end
        chk("dn_flag_before", int'(DOWN), 0);
        press_step(6'b100000);
        chk("down_from_sat", int'($signed(pitch_shift)), 6);
        chk("up_flag_held", int'(UP), 1);
        frame();
        chk("up_flag_cleared", int'(UP), 0);
        chk("dn_flag_set", int'(DOWN), 1);

        // Up and down together: no step.
        press_step(6'b110000);
        chk("up_dn_both", int'($signed(pitch_shift)), 6);

        // DOWN flash lasts exactly 15 frames.
        press_step(6'b100000);
        chk("down_again", int'($signed(pitch_shift)), 5);
        for (int i = 0; i < 15; i++) begin
            frame();
            chk($sformatf("dn_flash_f%0d", i), int'(DOWN), 1);
        end
        frame();
        chk("dn_flash_end", int'(DOWN), 0);

        // Bouncing high button: one press, one mute window.
        btn = '0;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            repeat (2) step();
        end
        btn[0] = 1'b1;
        rises = 0;
        mutes = 0;
        prev  = audio_mute;
        for (int i = 0; i < 60; i++) begin
            step();
            if (audio_mute && !prev) rises++;
            if (audio_mute) mutes++;
            prev = audio_mute;
        end
        chk("bounce_rises", rises, 1);
        chk("bounce_mute_cycles", mutes, 8);
        chk("bounce_sel", int'(effect_sel), 1);
        chk("pitch_cleared", int'($signed(pitch_shift)), 0);
        btn = '0;
        repeat (12) step();

        // Up while in LOW is ignored.
        do_eff("to_low", 6'b000010, 2);
        press_step(6'b010000);
        chk("up_in_low", int'($signed(pitch_shift)), 0);
        frame();
        chk("up_flag_in_low", int'(UP), 0);
        chk("low_flag", int'(LOW), 1);
        do_eff("low_off", 6'b000010, 0);

        // Echo press landing inside the mute is dropped.
        btn = 6'b001010;
        repeat (4) step();
        btn[2] = 1'b1;
        wait_mute_rise("drop");
        mute_len(n);
        chk("drop_mute_len", n, 8);
        chk("drop_sel", int'(effect_sel), 2);
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (audio_mute) rises++;
        end
        chk("drop_no_second_mute", rises, 0);
        btn = '0;
        repeat (20) step();
        chk("drop_final_sel", int'(effect_sel), 2);

        // Reset in the middle of a mute aborts it at once.
        btn = 6'b000100;
        wait_mute_rise("midrst");
        repeat (3) step();
        chk("midrst_muting", int'(audio_mute), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_mute", int'(audio_mute), 0);
        chk("midrst_sel", int'(effect_sel), 0);
        chk("midrst_flags", int'({HIGH, LOW, ECHO, PITCH, UP, DOWN}), 0);
        btn = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (20) step();
        chk("after_midrst_sel", int'(effect_sel), 0);
        chk("after_midrst_mute", int'(audio_mute), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
